// File: rtl/comp_acc.sv
// Complex accumulator: sums a programmable number of consecutive {xr,yr}
// products into one {xa,ya} dot-product result, wrapping in two's complement.
module comp_acc #(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 8,
    parameter int AWIDTH = 2*DWIDTH+2+LWIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sw_rst,
    input  logic [LWIDTH-1:0]             acc_len,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [2*(2*DWIDTH+2)-1:0]     in_data,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [2*AWIDTH-1:0]           out_data,
    output logic                          busy
);
    localparam int IWIDTH = 2*DWIDTH+2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [LWIDTH-1:0] LEN_ONE = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LWIDTH:0]   CNT_ONE = {{LWIDTH{1'b0}}, 1'b1};

    logic [1:0]               state_q, state_d;
    logic [LWIDTH-1:0]        len_q, len_d;
    logic [LWIDTH:0]          cnt_q, cnt_d;
    logic [AWIDTH-1:0]        xa_q, xa_d;
    logic [AWIDTH-1:0]        ya_q, ya_d;
    logic                     in_rdy_q, in_rdy_d;
    logic                     out_val_q, out_val_d;
    logic                     busy_q, busy_d;

    logic [IWIDTH-1:0]        xr, yr;
    logic [AWIDTH-1:0]        xr_ext, yr_ext;
    logic [LWIDTH-1:0]        len_new;
    logic [LWIDTH:0]          cnt_inc;
    logic                     in_ld;

    assign xr      = in_data[2*IWIDTH-1:IWIDTH];
    assign yr      = in_data[IWIDTH-1:0];
    assign xr_ext  = {{(AWIDTH-IWIDTH){xr[IWIDTH-1]}}, xr};
    assign yr_ext  = {{(AWIDTH-IWIDTH){yr[IWIDTH-1]}}, yr};
    assign len_new = (acc_len == '0) ? LEN_ONE : acc_len;
    assign cnt_inc = cnt_q + CNT_ONE;
    assign in_ld   = in_val & in_rdy_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        xa_d      = xa_q;
        ya_d      = ya_q;
        in_rdy_d  = in_rdy_q;
        out_val_d = out_val_q;
        case (state_q)
            S_IDLE: begin
                in_rdy_d = 1'b1;
                if (in_ld) begin
                    // First term of a frame loads rather than adds
                    len_d = len_new;
                    xa_d  = xr_ext;
                    ya_d  = yr_ext;
                    cnt_d = CNT_ONE;
                    if (len_new == LEN_ONE) begin
                        state_d   = S_OUT;
                        in_rdy_d  = 1'b0;
                        out_val_d = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (in_ld) begin
                    xa_d  = xa_q + xr_ext;
                    ya_d  = ya_q + yr_ext;
                    cnt_d = cnt_inc;
                    if (cnt_inc == {1'b0, len_q}) begin
                        state_d   = S_OUT;
                        in_rdy_d  = 1'b0;
                        out_val_d = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_rdy) begin
                    state_d   = S_IDLE;
                    in_rdy_d  = 1'b1;
                    out_val_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                in_rdy_d  = 1'b0;
                out_val_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Software reset shares the hardware reset values and wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (sw_rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            xa_q      <= xa_d;
            ya_q      <= ya_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
            busy_q    <= busy_d;
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_val  = out_val_q;
    assign out_data = {xa_q, ya_q};
    assign busy     = busy_q;

endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: directed and random frames checked against a plain
// integer-sum reference, with a second narrow-accumulator instance for wrap.
module tb_comp_acc;
    localparam int DW  = 8;
    localparam int LW  = 8;
    localparam int IW  = 2*DW+2;
    localparam int AW  = 2*DW+2+LW;
    localparam int AWW = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sw_rst;
    logic [LW-1:0]        acc_len;
    logic                 in_val;
    logic [2*IW-1:0]      in_data;
    logic                 out_rdy;
    logic                 in_rdy, out_val, busy;
    logic [2*AW-1:0]      out_data;
    logic                 in_rdy_w, out_val_w, busy_w;
    logic [2*AWW-1:0]     out_data_w;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    comp_acc #(.DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .acc_len(acc_len),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .busy(busy)
    );

    comp_acc #(.DWIDTH(DW), .LWIDTH(LW), .AWIDTH(AWW)) dut_w (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .acc_len(acc_len),
        .in_val(in_val), .in_rdy(in_rdy_w), .in_data(in_data),
        .out_val(out_val_w), .out_rdy(out_rdy), .out_data(out_data_w), .busy(busy_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one term from a negedge and hold it until accepted (bounded)
    task automatic push(input logic signed [IW-1:0] xr, input logic signed [IW-1:0] yr);
        int waitc;
        waitc   = 0;
        in_data = {xr, yr};
        in_val  = 1'b1;
        while (in_rdy !== 1'b1 && waitc < 20) begin
            @(posedge clk); @(negedge clk);
            waitc++;
        end
        check("in_rdy_wait", 64'(in_rdy), 64'd1);
        @(posedge clk); @(negedge clk);
        in_val = 1'b0;
    endtask

    // mode 0: random samples, otherwise every term is {fx,fy}
    task automatic send_frame(input int len_field, input int mode, input int fx, input int fy,
                              input int gap, input int hold);
        int                    n_terms;
        longint                sx, sy;
        logic signed [IW-1:0]  xr, yr;
        logic [AW-1:0]         ex, ey;
        logic [AWW-1:0]        ewx, ewy;
        n_terms = (len_field == 0) ? 1 : len_field;
        sx = 0;
        sy = 0;
        acc_len = LW'(len_field);
        for (int i = 0; i < n_terms; i++) begin
            if (i > 0 && gap > 0 && int'($urandom_range(99)) < gap) begin
                @(posedge clk); @(negedge clk);
            end
            if (mode == 0) begin
                xr = IW'($urandom);
                yr = IW'($urandom);
            end else begin
                xr = IW'(fx);
                yr = IW'(fy);
            end
            push(xr, yr);
            sx += longint'(xr);
            sy += longint'(yr);
            if (i == 0) acc_len = LW'($urandom);
            if (i < n_terms-1) begin
                check("mid_out_val", 64'(out_val), 64'd0);
                check("mid_busy", 64'(busy), 64'd1);
            end
        end
        ex  = AW'(sx);
        ey  = AW'(sy);
        ewx = AWW'(sx);
        ewy = AWW'(sy);
        check("out_val_rise", 64'(out_val), 64'd1);
        check("out_in_rdy_low", 64'(in_rdy), 64'd0);
        check("out_busy", 64'(busy), 64'd1);
        check("xa", 64'(out_data[2*AW-1:AW]), 64'(ex));
        check("ya", 64'(out_data[AW-1:0]), 64'(ey));
        check("xa_wrap20", 64'(out_data_w[2*AWW-1:AWW]), 64'(ewx));
        check("ya_wrap20", 64'(out_data_w[AWW-1:0]), 64'(ewy));
        out_rdy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            check("hold_out_val", 64'(out_val), 64'd1);
            check("hold_in_rdy", 64'(in_rdy), 64'd0);
            check("hold_data", 64'(out_data), 64'({ex, ey}));
        end
        out_rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        out_rdy = 1'b0;
        check("post_out_val", 64'(out_val), 64'd0);
        check("post_in_rdy", 64'(in_rdy), 64'd1);
        check("post_busy", 64'(busy), 64'd0);
        check("post_data_kept", 64'(out_data), 64'({ex, ey}));
    endtask

    initial begin
        rst_n   = 1'b0;
        sw_rst  = 1'b0;
        acc_len = '0;
        in_val  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_rdy_low", 64'(in_rdy), 64'd0);
        @(posedge clk); @(negedge clk);
        check("rel_in_rdy_high", 64'(in_rdy), 64'd1);

        // basic frame, then an immediate second frame
        send_frame(4, 1, 3, -2, 0, 0);
        check("basic_xa_const", 64'(out_data[2*AW-1:AW]), 64'd12);
        send_frame(4, 1, 3, -2, 0, 0);

        // length 0 and 1
        send_frame(0, 1, -5, 7, 0, 0);
        send_frame(1, 1, -5, 7, 0, 0);

        // bubbles and backpressure
        send_frame(3, 0, 0, 0, 100, 0);
        send_frame(3, 0, 0, 0, 0, 10);

        // long frames: no wrap at 26 bits, wrap at 20 bits
        send_frame(255, 1, 131071, 131071, 0, 0);
        send_frame(255, 1, -131072, 131071, 0, 2);

        for (int f = 0; f < 12; f++)
            send_frame(int'($urandom_range(20)), 0, 0, 0, 30, int'($urandom_range(3)));

        // hardware reset mid-frame (cnt=2)
        acc_len = LW'(5);
        push(18'sd10, -18'sd3);
        push(18'sd4, 18'sd9);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_val", 64'(out_val), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_rdy", 64'(in_rdy), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_low", 64'(in_rdy), 64'd0);
        @(posedge clk); @(negedge clk);
        check("arst_rel_high", 64'(in_rdy), 64'd1);
        send_frame(3, 0, 0, 0, 0, 0);

        // software reset while presenting a result with out_rdy high
        acc_len = LW'(2);
        push(IW'($urandom), IW'($urandom));
        push(IW'($urandom), IW'($urandom));
        check("sw_pre_out_val", 64'(out_val), 64'd1);
        out_rdy = 1'b1;
        sw_rst  = 1'b1;
        in_val  = 1'b1;
        in_data = 36'($urandom);
        @(posedge clk); @(negedge clk);
        sw_rst  = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        check("sw_out_val", 64'(out_val), 64'd0);
        check("sw_in_rdy", 64'(in_rdy), 64'd0);
        check("sw_busy", 64'(busy), 64'd0);
        check("sw_out_data", 64'(out_data), 64'd0);
        check("sw_out_data_w", 64'(out_data_w), 64'd0);
        @(posedge clk); @(negedge clk);
        check("sw_rel_in_rdy", 64'(in_rdy), 64'd1);
        send_frame(2, 1, 1, 1, 0, 0);
        check("sw_next_data", 64'(out_data), 64'({26'd2, 26'd2}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
